// File: rtl/store_write_buffer.sv
// Posted-store buffer between the CPU datapath and a combinational-read data memory.
// Stores retire into a small circular FIFO and drain to memory one per cycle whenever
// the memory port is not claimed by a load. Loads forward from the newest exact-address
// entry, read memory when nothing overlaps, and stall on a partial overlap until the
// overlapping entries have drained.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] CpuAddress,
    input  logic [DATA_W-1:0] CpuWriteData,
    input  logic              CpuMemWrite,
    input  logic              CpuMemRead,
    output logic [DATA_W-1:0] CpuReadData,
    output logic              Stall,
    input  logic              Drain,
    output logic              Empty,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Entry storage carries no reset: validity is derived purely from head/count.
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [DEPTH-1:0] entry_overlap;
    logic [DEPTH-1:0] entry_exact;

    // Per-entry overlap test against the current CPU address (modular arithmetic).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0]  age;
            logic              valid;
            logic [ADDR_W-1:0] fwd_diff;
            logic [ADDR_W-1:0] back_diff;
            assign age       = PTR_W'(gi) - head_reg;
            assign valid     = {1'b0, age} < count_reg;
            assign fwd_diff  = CpuAddress - addr_q[gi];
            assign back_diff = addr_q[gi] - CpuAddress;
            assign entry_overlap[gi] = valid &&
                                       ((fwd_diff <= ADDR_W'(2)) ||
                                        (back_diff == ADDR_W'(1)) ||
                                        (back_diff == ADDR_W'(2)));
            assign entry_exact[gi]   = (fwd_diff == '0);
        end
    endgenerate

    logic              hit;
    logic              hit_exact;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  scan_idx;

    // Scan oldest to newest so the newest overlapping entry decides forward vs stall.
    always_comb begin
        hit       = 1'b0;
        hit_exact = 1'b0;
        hit_data  = '0;
        scan_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (entry_overlap[scan_idx]) begin
                hit       = 1'b1;
                hit_exact = entry_exact[scan_idx];
                hit_data  = data_q[scan_idx];
            end
        end
    end

    logic full;
    logic enq;
    logic store_stall;
    logic load_port;
    logic load_stall;
    logic drain_go;

    // Port arbitration. With read and write both asserted the store is serviced and the
    // memory port is treated as a plain memory read, so no drain happens that cycle.
    always_comb begin
        full        = (count_reg == CNT_W'(DEPTH));
        store_stall = CpuMemWrite && (full || Drain);
        enq         = CpuMemWrite && !full && !Drain;
        load_port   = CpuMemRead && (CpuMemWrite || !hit);
        load_stall  = CpuMemRead && !CpuMemWrite && hit && !hit_exact;
        drain_go    = (count_reg != '0) && !load_port;
    end

    // Memory port and CPU-facing outputs; control outputs are forced low during reset.
    always_comb begin
        MemAddress   = drain_go ? addr_q[head_reg] : CpuAddress;
        MemWriteData = data_q[head_reg];
        MemWrite     = Reset && drain_go;
        MemRead      = Reset && load_port;
        Stall        = Reset && (store_stall || load_stall);
        CpuReadData  = hit ? hit_data : MemReadData;
        Empty        = (count_reg == '0);
    end

    // Pointer and occupancy update; a same-cycle drain does not free a slot for enqueue.
    always_comb begin
        head_next  = head_reg + PTR_W'(drain_go);
        tail_next  = tail_reg + PTR_W'(enq);
        count_next = count_reg + CNT_W'(enq) - CNT_W'(drain_go);
    end

    // FIFO state registers, cleared asynchronously so buffered stores are discarded.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry write at the tail on enqueue.
    always_ff @(posedge Clock) begin
        if (enq) begin
            addr_q[tail_reg] <= CpuAddress;
            data_q[tail_reg] <= CpuWriteData;
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a byte-wide big-endian memory model
// (256 bytes, address bits [7:0]) and a log of every memory write.
module tb_store_write_buffer;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [23:0] CpuAddress;
    logic [23:0] CpuWriteData;
    logic        CpuMemWrite;
    logic        CpuMemRead;
    logic [23:0] CpuReadData;
    logic        Stall;
    logic        Drain;
    logic        Empty;
    logic [23:0] MemAddress;
    logic [23:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [23:0] MemReadData;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];
    logic        mem_init = 1'b0;
    logic [47:0] wlog [$];
    logic [7:0]  a0, a1, a2;

    store_write_buffer #(.DEPTH(4), .ADDR_W(24), .DATA_W(24)) dut (
        .Clock(Clock), .Reset(Reset),
        .CpuAddress(CpuAddress), .CpuWriteData(CpuWriteData),
        .CpuMemWrite(CpuMemWrite), .CpuMemRead(CpuMemRead),
        .CpuReadData(CpuReadData), .Stall(Stall), .Drain(Drain), .Empty(Empty),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    always #5 Clock = ~Clock;

    assign a0 = MemAddress[7:0];
    assign a1 = MemAddress[7:0] + 8'd1;
    assign a2 = MemAddress[7:0] + 8'd2;
    assign MemReadData = {mem[a0], mem[a1], mem[a2]};

    // Memory model: fill with a known pattern once, then big-endian word writes.
    always @(posedge Clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
            mem_init <= 1'b1;
        end else if (MemWrite) begin
            mem[a0] <= MemWriteData[23:16];
            mem[a1] <= MemWriteData[15:8];
            mem[a2] <= MemWriteData[7:0];
            wlog.push_back({MemAddress, MemWriteData});
            $display("mem write addr=%06h data=%06h", MemAddress, MemWriteData);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        CpuMemRead  = 1'b0;
        CpuMemWrite = 1'b0;
        Drain       = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [23:0] a, input logic [23:0] d);
        CpuMemRead   = rd;
        CpuMemWrite  = wr;
        CpuAddress   = a;
        CpuWriteData = d;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        @(negedge Clock);
        while (Empty !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL %s: Empty=%b required 1 within 20 cycles", name, Empty);
        end
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        idle();
        drive(1'b1, 1'b1, 24'h000100, 24'h0);
        @(negedge Clock);
        checks += 4;
        if (Empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", Empty); end
        if (Stall !== 1'b0)    begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
        if (MemRead !== 1'b0)  begin errors++; $display("FAIL reset_memread: got %b want 0", MemRead); end
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite: got %b want 0", MemWrite); end
        tick();
        Reset = 1'b1;
        idle();
        CpuAddress = 24'h000123;
        @(negedge Clock);
        checks += 3;
        if (Empty !== 1'b1)            begin errors++; $display("FAIL idle_empty: got %b want 1", Empty); end
        if (MemWrite !== 1'b0 || MemRead !== 1'b0) begin errors++; $display("FAIL idle_port: wr=%b rd=%b want 0 0", MemWrite, MemRead); end
        if (MemAddress !== 24'h000123) begin errors++; $display("FAIL idle_addr: got %06h want 000123", MemAddress); end
        $display("test_reset done");
        tick();
    endtask

    task automatic test_store_drain();
        drive(1'b0, 1'b1, 24'h000010, 24'h123456);
        @(negedge Clock);
        checks += 3;
        if (Stall !== 1'b0)    begin errors++; $display("FAIL sd_stall: got %b want 0", Stall); end
        if (Empty !== 1'b1)    begin errors++; $display("FAIL sd_empty0: got %b want 1", Empty); end
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL sd_nowrite: got %b want 0", MemWrite); end
        tick();
        idle();
        @(negedge Clock);
        checks += 4;
        if (Empty !== 1'b0)              begin errors++; $display("FAIL sd_empty1: got %b want 0", Empty); end
        if (MemWrite !== 1'b1)           begin errors++; $display("FAIL sd_write: got %b want 1", MemWrite); end
        if (MemAddress !== 24'h000010)   begin errors++; $display("FAIL sd_addr: got %06h want 000010", MemAddress); end
        if (MemWriteData !== 24'h123456) begin errors++; $display("FAIL sd_data: got %06h want 123456", MemWriteData); end
        tick();
        @(negedge Clock);
        checks += 3;
        if (Empty !== 1'b1)    begin errors++; $display("FAIL sd_empty2: got %b want 1", Empty); end
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL sd_write2: got %b want 0", MemWrite); end
        if ({mem[8'h10], mem[8'h11], mem[8'h12]} !== 24'h123456)
            begin errors++; $display("FAIL sd_mem: got %02h%02h%02h want 123456", mem[8'h10], mem[8'h11], mem[8'h12]); end
        $display("test_store_drain done");
        tick();
    endtask

    task automatic test_full_stall();
        int base = wlog.size();
        logic [23:0] exp_a;
        // Load held alongside each store keeps the port busy, so nothing drains.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 24'h000040 + 24'(4 * i), 24'hA00000 + 24'(i));
            @(negedge Clock);
            checks += 2;
            if (Stall !== 1'b0)    begin errors++; $display("FAIL fs_store%0d_stall: got %b want 0", i, Stall); end
            if (MemWrite !== 1'b0 || MemRead !== 1'b1)
                begin errors++; $display("FAIL fs_store%0d_port: wr=%b rd=%b want 0 1", i, MemWrite, MemRead); end
            tick();
        end
        drive(1'b1, 1'b1, 24'h000050, 24'hA00004);
        @(negedge Clock);
        checks += 2;
        if (Stall !== 1'b1)    begin errors++; $display("FAIL fs_fifth_stall: got %b want 1", Stall); end
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL fs_fifth_nowrite: got %b want 0", MemWrite); end
        tick();
        CpuMemRead = 1'b0;
        @(negedge Clock);
        checks += 3;
        if (Stall !== 1'b1)            begin errors++; $display("FAIL fs_release_stall: got %b want 1", Stall); end
        if (MemWrite !== 1'b1)         begin errors++; $display("FAIL fs_release_write: got %b want 1", MemWrite); end
        if (MemAddress !== 24'h000040) begin errors++; $display("FAIL fs_release_addr: got %06h want 000040", MemAddress); end
        tick();
        @(negedge Clock);
        checks += 2;
        if (Stall !== 1'b0)            begin errors++; $display("FAIL fs_enq_stall: got %b want 0", Stall); end
        if (MemAddress !== 24'h000044) begin errors++; $display("FAIL fs_enq_addr: got %06h want 000044", MemAddress); end
        tick();
        idle();
        wait_empty("fs_empty");
        checks++;
        if (wlog.size() !== base + 5) begin errors++; $display("FAIL fs_count: got %0d writes want 5", wlog.size() - base); end
        for (int i = 0; i < 5 && base + i < wlog.size(); i++) begin
            exp_a = (i == 4) ? 24'h000050 : 24'h000040 + 24'(4 * i);
            checks++;
            if (wlog[base + i] !== {exp_a, 24'hA00000 + 24'(i)})
                begin errors++; $display("FAIL fs_order%0d: got %012h want %06h%06h", i, wlog[base + i], exp_a, 24'hA00000 + 24'(i)); end
        end
        $display("test_full_stall done");
    endtask

    task automatic test_forward();
        int base = wlog.size();
        drive(1'b1, 1'b1, 24'h000020, 24'hAABBCC);
        tick();
        drive(1'b1, 1'b1, 24'h000020, 24'h112233);
        @(negedge Clock);
        checks++;
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL fw_hold: got %b want 0", MemWrite); end
        tick();
        drive(1'b1, 1'b0, 24'h000020, 24'h0);
        @(negedge Clock);
        checks += 4;
        if (CpuReadData !== 24'h112233)  begin errors++; $display("FAIL fw_data: got %06h want 112233", CpuReadData); end
        if (Stall !== 1'b0)              begin errors++; $display("FAIL fw_stall: got %b want 0", Stall); end
        if (MemRead !== 1'b0 || MemWrite !== 1'b1)
            begin errors++; $display("FAIL fw_port: rd=%b wr=%b want 0 1", MemRead, MemWrite); end
        if (MemWriteData !== 24'hAABBCC) begin errors++; $display("FAIL fw_drain_old: got %06h want AABBCC", MemWriteData); end
        tick();
        @(negedge Clock);
        checks += 2;
        if (CpuReadData !== 24'h112233)  begin errors++; $display("FAIL fw_data2: got %06h want 112233", CpuReadData); end
        if (MemWriteData !== 24'h112233) begin errors++; $display("FAIL fw_drain_new: got %06h want 112233", MemWriteData); end
        tick();
        idle();
        wait_empty("fw_empty");
        checks += 2;
        if ({mem[8'h20], mem[8'h21], mem[8'h22]} !== 24'h112233)
            begin errors++; $display("FAIL fw_mem: got %02h%02h%02h want 112233", mem[8'h20], mem[8'h21], mem[8'h22]); end
        if (wlog.size() !== base + 2) begin errors++; $display("FAIL fw_count: got %0d writes want 2", wlog.size() - base); end
        $display("test_forward done");
    endtask

    task automatic test_partial();
        drive(1'b1, 1'b1, 24'h000021, 24'hDDEEFF);
        tick();
        drive(1'b1, 1'b0, 24'h000020, 24'h0);
        @(negedge Clock);
        checks += 3;
        if (Stall !== 1'b1)            begin errors++; $display("FAIL pt_stall: got %b want 1", Stall); end
        if (MemWrite !== 1'b1 || MemRead !== 1'b0)
            begin errors++; $display("FAIL pt_port: wr=%b rd=%b want 1 0", MemWrite, MemRead); end
        if (MemAddress !== 24'h000021) begin errors++; $display("FAIL pt_addr: got %06h want 000021", MemAddress); end
        tick();
        @(negedge Clock);
        checks += 3;
        if (Stall !== 1'b0)             begin errors++; $display("FAIL pt_release: got %b want 0", Stall); end
        if (MemRead !== 1'b1)           begin errors++; $display("FAIL pt_read: got %b want 1", MemRead); end
        if (CpuReadData !== 24'h11DDEE) begin errors++; $display("FAIL pt_data: got %06h want 11DDEE", CpuReadData); end
        $display("test_partial done");
        tick();
        idle();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 24'hFFFFFF, 24'h445566);
        tick();
        drive(1'b1, 1'b0, 24'h000000, 24'h0);
        @(negedge Clock);
        checks += 2;
        if (Stall !== 1'b1)            begin errors++; $display("FAIL wr_stall: got %b want 1", Stall); end
        if (MemAddress !== 24'hFFFFFF) begin errors++; $display("FAIL wr_addr: got %06h want FFFFFF", MemAddress); end
        tick();
        @(negedge Clock);
        checks += 2;
        if (Stall !== 1'b0)             begin errors++; $display("FAIL wr_release: got %b want 0", Stall); end
        if (CpuReadData !== 24'h5566A7) begin errors++; $display("FAIL wr_data: got %06h want 5566A7", CpuReadData); end
        $display("test_wrap done");
        tick();
        idle();
    endtask

    task automatic test_reset_mid_drain();
        int base;
        drive(1'b1, 1'b1, 24'h000030, 24'h0B0B0B);
        tick();
        drive(1'b1, 1'b1, 24'h000034, 24'h0C0C0C);
        tick();
        idle();
        base = wlog.size();
        @(negedge Clock);
        checks += 2;
        if (MemWrite !== 1'b1 || MemAddress !== 24'h000030)
            begin errors++; $display("FAIL rm_draining: wr=%b addr=%06h want 1 000030", MemWrite, MemAddress); end
        if (Empty !== 1'b0) begin errors++; $display("FAIL rm_full: got %b want 0", Empty); end
        Reset = 1'b0;
        #1;
        checks += 3;
        if (Empty !== 1'b1)    begin errors++; $display("FAIL rm_empty: got %b want 1", Empty); end
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL rm_write: got %b want 0", MemWrite); end
        if (Stall !== 1'b0)    begin errors++; $display("FAIL rm_stall: got %b want 0", Stall); end
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        @(negedge Clock);
        checks += 2;
        if (Empty !== 1'b1 || MemWrite !== 1'b0)
            begin errors++; $display("FAIL rm_after: empty=%b wr=%b want 1 0", Empty, MemWrite); end
        if (wlog.size() !== base) begin errors++; $display("FAIL rm_nowrites: got %0d writes want 0", wlog.size() - base); end
        $display("test_reset_mid_drain done");
        tick();
    endtask

    task automatic test_drain();
        int base = wlog.size();
        drive(1'b1, 1'b1, 24'h000060, 24'h010203);
        tick();
        drive(1'b0, 1'b1, 24'h000064, 24'h040506);
        Drain = 1'b1;
        @(negedge Clock);
        checks += 2;
        if (Stall !== 1'b1) begin errors++; $display("FAIL dr_stall: got %b want 1", Stall); end
        if (MemWrite !== 1'b1 || MemAddress !== 24'h000060)
            begin errors++; $display("FAIL dr_flush: wr=%b addr=%06h want 1 000060", MemWrite, MemAddress); end
        tick();
        @(negedge Clock);
        checks += 2;
        if (Stall !== 1'b1)    begin errors++; $display("FAIL dr_stall2: got %b want 1", Stall); end
        if (Empty !== 1'b1 || MemWrite !== 1'b0)
            begin errors++; $display("FAIL dr_empty: empty=%b wr=%b want 1 0", Empty, MemWrite); end
        tick();
        Drain = 1'b0;
        @(negedge Clock);
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL dr_release: got %b want 0", Stall); end
        tick();
        idle();
        wait_empty("dr_empty_end");
        checks += 2;
        if (wlog.size() !== base + 2) begin errors++; $display("FAIL dr_count: got %0d writes want 2", wlog.size() - base); end
        else if (wlog[base] !== {24'h000060, 24'h010203} || wlog[base + 1] !== {24'h000064, 24'h040506})
            begin errors++; $display("FAIL dr_order: got %012h %012h want 000060010203 000064040506", wlog[base], wlog[base + 1]); end
        $display("test_drain done");
    endtask

    initial begin
        CpuAddress   = '0;
        CpuWriteData = '0;
        test_reset();
        test_store_drain();
        test_full_stall();
        test_forward();
        test_partial();
        test_wrap();
        test_reset_mid_drain();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
